// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: synchronizes freq_in, counts its rising edges over an edge-aligned gate window and latches the result
module freq_gate_ctrl #(
    parameter int GATE_W      = 24,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freq_in,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_len,
    output logic              busy,
    output logic [CNT_W-1:0]  result,
    output logic              result_valid,
    output logic              overflow,
    output logic              timeout
);
    localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, GATE = 2'd2;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev, edge_det, sat_now, last, kill;
    logic [1:0]             state, state_nx;
    logic [GATE_W-1:0]      timer, gate_reg;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic                   ovf_int;
    assign edge_det = sync[SYNC_STAGES-1] & ~prev;
    assign sat_now  = edge_det & (&cnt);
    assign cnt_nx   = (edge_det && !(&cnt)) ? cnt + 1'b1 : cnt;
    assign last     = timer == GATE_W'(1);
    assign kill     = abort && state != IDLE;
    always_comb begin
        state_nx = IDLE;
        if (kill)
            state_nx = IDLE;
        else if (state == IDLE)
            state_nx = (start && gate_len != '0) ? ARM : IDLE;
        else if (state == ARM)
            state_nx = edge_det ? GATE : (last && !continuous) ? IDLE : ARM;
        else if (state == GATE)
            state_nx = (last && !continuous) ? IDLE : GATE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync         <= '0;
            prev         <= 1'b0;
            state        <= IDLE;
            busy         <= 1'b0;
            timer        <= '0;
            gate_reg     <= '0;
            cnt          <= '0;
            ovf_int      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            sync         <= {sync[SYNC_STAGES-2:0], freq_in};
            prev         <= sync[SYNC_STAGES-1];
            state        <= state_nx;
            busy         <= state_nx != IDLE;
            result_valid <= 1'b0;
            if (!kill && state == IDLE && start && gate_len != '0) begin
                gate_reg <= gate_len;
                timer    <= gate_len;
                cnt      <= '0;
                ovf_int  <= 1'b0;
            end else if (!kill && state == ARM) begin
                // the arming edge only aligns the window; it is not counted
                if (edge_det) begin
                    timer <= gate_reg;
                    cnt   <= '0;
                end else if (last) begin
                    timer        <= gate_reg;
                    result       <= '0;
                    overflow     <= 1'b0;
                    timeout      <= 1'b1;
                    result_valid <= 1'b1;
                end else begin
                    timer <= timer - 1'b1;
                end
            end else if (!kill && state == GATE) begin
                if (last) begin
                    timer        <= gate_reg;
                    cnt          <= '0;
                    ovf_int      <= 1'b0;
                    result       <= cnt_nx;
                    overflow     <= ovf_int | sat_now;
                    timeout      <= 1'b0;
                    result_valid <= 1'b1;
                end else begin
                    timer   <= timer - 1'b1;
                    cnt     <= cnt_nx;
                    ovf_int <= ovf_int | sat_now;
                end
            end
        end
    end
endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb_freq_gate_ctrl: directed stimulus with a result scoreboard popped by an independent monitor
module tb_freq_gate_ctrl;
    logic        clk = 1'b0, rst = 1'b1, freq_in = 1'b0, start = 1'b0, continuous = 1'b0, abort = 1'b0;
    logic [23:0] gate_len = '0;
    logic        busy, result_valid, overflow, timeout;
    logic [7:0]  result;
    typedef struct packed {
        logic [7:0]  res;
        logic        ovf;
        logic        to;
        logic        bz;
        logic [15:0] gap;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int total = 0, bad = 0, nvalid = 0, cyc = 0, last_cyc = 0, s_cyc = 0, fper = 0, ph = 0;

    freq_gate_ctrl #(.GATE_W(24), .CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .freq_in(freq_in), .start(start), .continuous(continuous),
        .abort(abort), .gate_len(gate_len), .busy(busy), .result(result),
        .result_valid(result_valid), .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] b);
        total++;
        if (a !== b) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", n, a, b);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (fper < 2) begin
                freq_in = 1'b0;
                ph = 0;
            end else begin
                freq_in = ph < fper / 2;
                ph = (ph + 1 >= fper) ? 0 : ph + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && result_valid) begin
            nvalid++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid result=%0d", result);
            end else begin
                e = q.pop_front();
                chk("result", result, e.res);
                chk("overflow", overflow, e.ovf);
                chk("timeout", timeout, e.to);
                chk("busy_at_valid", busy, e.bz);
                if (e.gap != 0) chk("valid_gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
        end
    end

    task automatic do_start(input int gl);
        @(negedge clk);
        gate_len = gl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic wait_valid(input int n, input int bound);
        int k = 0;
        while (nvalid < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk("valid_count", nvalid, n);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;
        // single shot, 100 edges in 1000 cycles
        fper = 10;
        repeat (20) @(negedge clk);
        q.push_back('{8'd100, 1'b0, 1'b0, 1'b0, 16'd0});
        do_start(1000);
        wait_valid(1, 1200);
        // reset in the middle of a window
        do_start(1000);
        repeat (390) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_timeout", timeout, 0);
        rst = 1'b0;
        // saturation, then a clean short run
        fper = 4;
        repeat (10) @(negedge clk);
        q.push_back('{8'd255, 1'b1, 1'b0, 1'b0, 16'd0});
        do_start(1200);
        wait_valid(2, 1500);
        q.push_back('{8'd5, 1'b0, 1'b0, 1'b0, 16'd0});
        do_start(20);
        wait_valid(3, 100);
        // no edges: timeout after 50 ARM cycles
        fper = 0;
        repeat (10) @(negedge clk);
        q.push_back('{8'd0, 1'b0, 1'b1, 1'b0, 16'd0});
        do_start(50);
        wait_valid(4, 100);
        chk("arm_len", last_cyc - s_cyc, 50);
        // start and gate_len changes while busy are ignored
        fper = 10;
        repeat (20) @(negedge clk);
        q.push_back('{8'd20, 1'b0, 1'b0, 1'b0, 16'd0});
        do_start(200);
        repeat (50) @(negedge clk);
        gate_len = 7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        gate_len = 3;
        wait_valid(5, 400);
        // abort mid-window
        do_start(200);
        repeat (100) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 20);
        repeat (300) @(negedge clk);
        chk("abort_no_valid", nvalid, 5);
        // continuous, gapless windows
        fper = 5;
        continuous = 1'b1;
        repeat (10) @(negedge clk);
        q.push_back('{8'd20, 1'b0, 1'b0, 1'b1, 16'd0});
        for (int i = 0; i < 8; i++) q.push_back('{8'd20, 1'b0, 1'b0, 1'b1, 16'd100});
        q.push_back('{8'd20, 1'b0, 1'b0, 1'b0, 16'd100});
        do_start(100);
        wait_valid(14, 1100);
        continuous = 1'b0;
        wait_valid(15, 200);
        repeat (300) @(negedge clk);
        chk("cont_end_count", nvalid, 15);
        chk("cont_end_busy", busy, 0);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
